// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: mode sequencer for the 8-LED bank and the active-low RGB LED.
// Steps through four display modes (COUNT, SHIFT, BOUNCE, BLINK). Each mode is
// paced by a tick prescaler and auto-advances after STEPS_PER_MODE ticks. A
// requester can force a mode change with a valid/ready handshake.
//
// Optional build macro: LED_SEQ_PWM_EN
//   defined   -> leds/rgb outputs are gated by a free-running 4-bit PWM
//                against duty_i at the output register
//   undefined -> duty_i is ignored, outputs are ungated
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | outputs dark, prescaler/step cleared, waits for en_i
//   LOAD  | one cycle: loads the initial pattern and colour for mode_q
//   RUN   | prescaler running, pattern steps on each tick, accepts requests
module led_seq_ctrl #(
    parameter int unsigned TICK_DIV       = 8388608,
    parameter int unsigned STEPS_PER_MODE = 256,
    parameter int unsigned CW             = 28
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       mode_sel_valid_i,
    input  logic [1:0] mode_sel_i,
    output logic       mode_sel_ready_o,
    input  logic [3:0] duty_i,
    output logic [7:0] leds_o,
    output logic [2:0] rgb_n_o,
    output logic [1:0] mode_o,
    output logic       tick_o,
    output logic       busy_o
);

    localparam int unsigned SW = (STEPS_PER_MODE > 1) ? $clog2(STEPS_PER_MODE) : 1;
    localparam logic [CW-1:0] PRESC_LAST = CW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEPS_PER_MODE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [1:0] M_COUNT  = 2'd0;
    localparam logic [1:0] M_SHIFT  = 2'd1;
    localparam logic [1:0] M_BOUNCE = 2'd2;
    localparam logic [1:0] M_BLINK  = 2'd3;

    state_t        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [7:0]    pat_q, pat_d;
    logic          dir_q, dir_d;       // BOUNCE direction: 0 = left, 1 = right
    logic [CW-1:0] presc_q, presc_d;
    logic [SW-1:0] step_q, step_d;
    logic          tick_q, tick_d;
    logic [7:0]    leds_q, leds_d;
    logic [2:0]    rgb_n_q, rgb_n_d;
    logic [2:0]    rgb_base;
    logic          wrap;
    logic          accept;

    function automatic logic [7:0] init_pat(input logic [1:0] m);
        logic [7:0] p;
        p = 8'hFF;
        case (m)
            M_COUNT:  p = 8'hFF;
            M_SHIFT:  p = 8'h01;
            M_BOUNCE: p = 8'h01;
            M_BLINK:  p = 8'hFF;
            default:  p = 8'hFF;
        endcase
        return p;
    endfunction

    function automatic logic [2:0] mode_colour(input logic [1:0] m);
        logic [2:0] c;
        c = 3'b111;
        case (m)
            M_COUNT:  c = 3'b000;
            M_SHIFT:  c = 3'b110;
            M_BOUNCE: c = 3'b101;
            M_BLINK:  c = 3'b011;
            default:  c = 3'b111;
        endcase
        return c;
    endfunction

    assign mode_sel_ready_o = (state_q == ST_RUN) && en_i;
    assign busy_o           = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign accept           = mode_sel_valid_i && mode_sel_ready_o;
    assign wrap             = (presc_q == PRESC_LAST);

    // Next-state, prescaler, step and pattern update
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        pat_d    = pat_q;
        dir_d    = dir_q;
        presc_d  = presc_q;
        step_d   = step_q;
        tick_d   = 1'b0;
        rgb_base = 3'b111;

        case (state_q)
            ST_IDLE: begin
                pat_d   = 8'h00;
                dir_d   = 1'b0;
                presc_d = '0;
                step_d  = '0;
                if (en_i) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                pat_d    = init_pat(mode_q);
                dir_d    = 1'b0;
                presc_d  = '0;
                step_d   = '0;
                rgb_base = mode_colour(mode_q);
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                rgb_base = mode_colour(mode_q);
                tick_d   = wrap;
                presc_d  = wrap ? '0 : presc_q + CW'(1);
                if (accept) begin
                    mode_d  = mode_sel_i;
                    state_d = ST_LOAD;
                end else if (wrap) begin
                    if (step_q == STEP_LAST) begin
                        mode_d  = mode_q + 2'd1;
                        state_d = ST_LOAD;
                    end else begin
                        step_d = step_q + SW'(1);
                        case (mode_q)
                            M_COUNT: pat_d = pat_q - 8'd1;
                            M_SHIFT: pat_d = {pat_q[6:0], pat_q[7]};
                            M_BOUNCE: begin
                                if (!dir_q) begin
                                    pat_d = {pat_q[6:0], 1'b0};
                                    if (pat_d == 8'h80) dir_d = 1'b1;
                                end else begin
                                    pat_d = {1'b0, pat_q[7:1]};
                                    if (pat_d == 8'h01) dir_d = 1'b0;
                                end
                            end
                            M_BLINK: pat_d = ~pat_q;
                            default: pat_d = pat_q;
                        endcase
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Dropping enable overrides everything except reset
        if (!en_i) begin
            state_d  = ST_IDLE;
            pat_d    = 8'h00;
            dir_d    = 1'b0;
            presc_d  = '0;
            step_d   = '0;
            tick_d   = 1'b0;
            rgb_base = 3'b111;
        end
    end

`ifdef LED_SEQ_PWM_EN
    logic [3:0] pwm_q;
    logic       pwm_on;

    assign pwm_on = (pwm_q < duty_i);

    // Free-running PWM phase counter
    always_ff @(posedge clk_i) begin
        if (rst_i) pwm_q <= 4'd0;
        else       pwm_q <= pwm_q + 4'd1;
    end

    // Output gating: off-phase forces leds dark and rgb channels high
    always_comb begin
        leds_d  = pwm_on ? pat_d : 8'h00;
        rgb_n_d = pwm_on ? rgb_base : 3'b111;
    end
`else
    logic unused_duty;
    assign unused_duty = ^duty_i;

    // Ungated outputs
    always_comb begin
        leds_d  = pat_d;
        rgb_n_d = rgb_base;
    end
`endif

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            mode_q  <= 2'd0;
            pat_q   <= 8'h00;
            dir_q   <= 1'b0;
            presc_q <= '0;
            step_q  <= '0;
            tick_q  <= 1'b0;
            leds_q  <= 8'h00;
            rgb_n_q <= 3'b111;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pat_q   <= pat_d;
            dir_q   <= dir_d;
            presc_q <= presc_d;
            step_q  <= step_d;
            tick_q  <= tick_d;
            leds_q  <= leds_d;
            rgb_n_q <= rgb_n_d;
        end
    end

    assign leds_o  = leds_q;
    assign rgb_n_o = rgb_n_q;
    assign mode_o  = mode_q;
    assign tick_o  = tick_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with TICK_DIV=4. Instance u_a uses
// STEPS_PER_MODE=4, instance u_b uses STEPS_PER_MODE=20 for the BOUNCE run.
module tb_led_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       va, vb;
    logic [1:0] sa, sb;
    logic [3:0] duty;

    logic       a_ready, a_tick, a_busy;
    logic [7:0] a_leds;
    logic [2:0] a_rgb;
    logic [1:0] a_mode;
    logic       b_ready, b_tick, b_busy;
    logic [7:0] b_leds;
    logic [2:0] b_rgb;
    logic [1:0] b_mode;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_leds [17] = '{8'hFF, 8'hFE, 8'hFD, 8'hFC,
                                  8'h01, 8'h02, 8'h04, 8'h08,
                                  8'h01, 8'h02, 8'h04, 8'h08,
                                  8'hFF, 8'h00, 8'hFF, 8'h00,
                                  8'hFF};
    logic [1:0] exp_mode [17] = '{2'd0, 2'd0, 2'd0, 2'd0,
                                  2'd1, 2'd1, 2'd1, 2'd1,
                                  2'd2, 2'd2, 2'd2, 2'd2,
                                  2'd3, 2'd3, 2'd3, 2'd3,
                                  2'd0};
    logic [2:0] exp_rgb [17]  = '{3'b000, 3'b000, 3'b000, 3'b000,
                                  3'b110, 3'b110, 3'b110, 3'b110,
                                  3'b101, 3'b101, 3'b101, 3'b101,
                                  3'b011, 3'b011, 3'b011, 3'b011,
                                  3'b000};
    logic [7:0] bounce_seq [9] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                                   8'h40, 8'h80, 8'h40, 8'h20};

    always #5 clk = ~clk;

    led_seq_ctrl #(.TICK_DIV(4), .STEPS_PER_MODE(4), .CW(28)) u_a (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .mode_sel_valid_i(va), .mode_sel_i(sa), .mode_sel_ready_o(a_ready),
        .duty_i(duty), .leds_o(a_leds), .rgb_n_o(a_rgb), .mode_o(a_mode),
        .tick_o(a_tick), .busy_o(a_busy)
    );

    led_seq_ctrl #(.TICK_DIV(4), .STEPS_PER_MODE(20), .CW(28)) u_b (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .mode_sel_valid_i(vb), .mode_sel_i(sb), .mode_sel_ready_o(b_ready),
        .duty_i(duty), .leds_o(b_leds), .rgb_n_o(b_rgb), .mode_o(b_mode),
        .tick_o(b_tick), .busy_o(b_busy)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        va   = 1'b0; sa = 2'd0;
        vb   = 1'b0; sb = 2'd0;
        duty = 4'hF;

        // Reset held with en high
        cyc(3);
        chk("rst_leds",  a_leds,  8'h00);
        chk("rst_rgb",   a_rgb,   3'b111);
        chk("rst_mode",  a_mode,  2'd0);
        chk("rst_busy",  a_busy,  1'b0);
        chk("rst_ready", a_ready, 1'b0);
        chk("rst_tick",  a_tick,  1'b0);

        rst = 1'b0;
        cyc(1);
        chk("load_busy",  a_busy,  1'b1);
        chk("load_leds",  a_leds,  8'h00);
        chk("load_ready", a_ready, 1'b0);
        cyc(1);
        chk("start_leds",  a_leds,  8'hFF);
        chk("start_rgb",   a_rgb,   3'b000);
        chk("start_ready", a_ready, 1'b1);

        // Full mode sequence and wrap back to COUNT
        for (int i = 1; i < 17; i++) begin
            cyc(3);
            chk("tick_gap", a_tick, 1'b0);
            cyc(1);
            chk("tick_pulse", a_tick, 1'b1);
            if (i % 4 == 0) begin
                chk("adv_mode",  a_mode,  exp_mode[i]);
                chk("adv_ready", a_ready, 1'b0);
                chk("adv_busy",  a_busy,  1'b1);
                chk("adv_hold",  a_leds,  exp_leds[i-1]);
                cyc(1);
            end
            chk("seq_leds", a_leds, exp_leds[i]);
            chk("seq_mode", a_mode, exp_mode[i]);
            chk("seq_rgb",  a_rgb,  exp_rgb[i]);
        end

        // Request lands on the final tick of mode 0: request wins
        cyc(15);
        va = 1'b1; sa = 2'd3;
        cyc(1);
        chk("req_mode",  a_mode,  2'd3);
        chk("req_hold",  a_leds,  8'hFC);
        chk("req_ready", a_ready, 1'b0);
        va = 1'b0;
        cyc(1);
        chk("req_leds",  a_leds,  8'hFF);
        chk("req_rgb",   a_rgb,   3'b011);
        chk("req_ready1", a_ready, 1'b1);

        // Force mode 1, then drop enable mid-run
        va = 1'b1; sa = 2'd1;
        cyc(1);
        chk("sel1_mode", a_mode, 2'd1);
        va = 1'b0;
        cyc(1);
        chk("sel1_leds", a_leds, 8'h01);
        chk("sel1_rgb",  a_rgb,  3'b110);
        cyc(4);
        chk("sel1_step", a_leds, 8'h02);
        cyc(1);
        en = 1'b0;
        cyc(1);
        chk("dis_leds",  a_leds,  8'h00);
        chk("dis_rgb",   a_rgb,   3'b111);
        chk("dis_busy",  a_busy,  1'b0);
        chk("dis_ready", a_ready, 1'b0);
        chk("dis_mode",  a_mode,  2'd1);
        va = 1'b1; sa = 2'd2;
        cyc(2);
        chk("idle_ignore", a_mode, 2'd1);
        chk("idle_leds",   a_leds, 8'h00);
        va = 1'b0;
        en = 1'b1;
        cyc(1);
        chk("reen_busy", a_busy, 1'b1);
        chk("reen_load", a_leds, 8'h00);
        cyc(1);
        chk("reen_leds", a_leds, 8'h01);
        chk("reen_mode", a_mode, 2'd1);
        chk("reen_rgb",  a_rgb,  3'b110);

        // Reset in the middle of RUN
        cyc(2);
        rst = 1'b1;
        cyc(1);
        chk("mrst_leds", a_leds, 8'h00);
        chk("mrst_rgb",  a_rgb,  3'b111);
        chk("mrst_mode", a_mode, 2'd0);
        chk("mrst_busy", a_busy, 1'b0);
        chk("mrst_tick", a_tick, 1'b0);

        // BOUNCE reversal on the long-mode instance
        cyc(1);
        rst = 1'b0;
        cyc(2);
        chk("b_start", b_leds, 8'hFF);
        vb = 1'b1; sb = 2'd2;
        cyc(1);
        chk("b_mode", b_mode, 2'd2);
        vb = 1'b0;
        cyc(1);
        chk("b_init", b_leds, 8'h01);
        chk("b_rgb",  b_rgb,  3'b101);
        for (int j = 0; j < 9; j++) begin
            cyc(4);
            chk("bounce", b_leds, bounce_seq[j]);
        end
        chk("b_mode_end", b_mode, 2'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
